// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the reset / exception-vector addresses, the IF state encoding and a
// small helper used to detect word-misaligned fetch addresses.
package instr_fetch_pkg;

    // First fetch address after reset (boot ROM, kseg1).
    localparam logic [31:0] RESET_PC        = 32'hBFC0_0000;
    // General exception vector with BEV=1 and BEV=0.
    localparam logic [31:0] EXC_VECTOR_BEV  = 32'hBFC0_0380;
    localparam logic [31:0] EXC_VECTOR_NORM = 32'h8000_0180;

    // IF stage state encoding.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_DATA = 2'd1,
        S_HOLD = 2'd2
    } if_state_e;

    // A fetch address is legal only when word aligned; anything else is AdEL.
    function automatic logic addr_misaligned(input logic [1:0] addr_lo);
        return (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// SRAM-like instruction port between the fetch stage (master) and the
// instruction memory (slave). One outstanding request at a time.
//   inst_req / inst_addr        : request, address held while not accepted
//   inst_addr_ok                : address accepted this cycle
//   inst_data_ok / inst_rdata   : read data returned this cycle
interface instr_fetch_if #(
    parameter int DATA_W = 32
);
    logic              inst_req;
    logic [DATA_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/instr_fetch_pc_sel.sv
// Next-PC selection for the fetch stage (purely combinational).
// Priority: flush restart PC > pending branch/jump target > sequential pc+4.
// Ports:
//   flush / flush_pc                   : commit-stage flush and its restart PC
//   redirect_pend / redirect_target    : latched taken branch awaiting delay slot
//   pc                                 : current fetch PC
//   next_pc                            : selected next fetch PC (wraps mod 2^DATA_W)
module if_pc_sel #(
    parameter int DATA_W = 32
) (
    input  logic              flush,
    input  logic [DATA_W-1:0] flush_pc,
    input  logic              redirect_pend,
    input  logic [DATA_W-1:0] redirect_target,
    input  logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] next_pc
);

    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(3'd4);

    logic [DATA_W-1:0] seq_pc_s;

    // Sequential successor; the adder simply wraps at the top of the space.
    always_comb begin
        seq_pc_s = pc + PC_STEP;
    end

    // Priority mux for the next fetch address.
    always_comb begin
        next_pc = seq_pc_s;
        if (flush) begin
            next_pc = flush_pc;
        end else if (redirect_pend) begin
            next_pc = redirect_target;
        end else begin
            next_pc = seq_pc_s;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage feeding instr_decode.
// Owns the PC, issues one request at a time on the SRAM-like port, applies
// branch redirects after the delay slot, handles exception/ERET flushes and
// holds the delivered instruction stable while decode stalls.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   inst_bus (master)    : instruction SRAM-like port
//   id_stall_i           : decode cannot accept this cycle
//   branch_taken_i/target: taken branch/jump resolved in decode
//   flush_i/flush_pc_i   : exception/ERET flush and restart PC
//   if_valid_o/instr/pc/adel : registered outputs to decode
module instr_fetch #(
    parameter logic [31:0] RESET_PC = instr_fetch_pkg::RESET_PC,
    parameter int          DATA_W   = 32
) (
    input  logic               clk,
    input  logic               resetn,
    instr_fetch_if.master      inst_bus,
    input  logic               id_stall_i,
    input  logic               branch_taken_i,
    input  logic [DATA_W-1:0]  branch_target_i,
    input  logic               flush_i,
    input  logic [DATA_W-1:0]  flush_pc_i,
    output logic               if_valid_o,
    output logic [DATA_W-1:0]  if_instr_o,
    output logic [DATA_W-1:0]  if_pc_o,
    output logic               if_adel_o
);

    import instr_fetch_pkg::*;

    if_state_e         state_r, state_next_s;
    logic [DATA_W-1:0] pc_r, pc_next_s;
    logic              req_r, req_next_s;
    logic              valid_r, valid_next_s;
    logic [DATA_W-1:0] instr_r, instr_next_s;
    logic [DATA_W-1:0] out_pc_r, out_pc_next_s;
    logic              adel_r, adel_next_s;
    logic              cancel_r, cancel_next_s;
    logic              redir_pend_r, redir_pend_next_s;
    logic [DATA_W-1:0] redir_target_r, redir_target_next_s;
    logic              suppress_req_s;
    logic              branch_ok_s;
    logic [DATA_W-1:0] sel_pc_s;

    if_pc_sel #(.DATA_W(DATA_W)) u_pc_sel (
        .flush           (flush_i),
        .flush_pc        (flush_pc_i),
        .redirect_pend   (redir_pend_r),
        .redirect_target (redir_target_r),
        .pc              (pc_r),
        .next_pc         (sel_pc_s)
    );

    // A branch only counts when decode actually advances and no flush overrides it.
    always_comb begin
        branch_ok_s = branch_taken_i && !id_stall_i && !flush_i;
    end

    // Next-state, PC, redirect bookkeeping and decode-side output values.
    always_comb begin
        state_next_s        = state_r;
        pc_next_s           = pc_r;
        valid_next_s        = valid_r;
        instr_next_s        = instr_r;
        out_pc_next_s       = out_pc_r;
        adel_next_s         = adel_r;
        cancel_next_s       = cancel_r;
        redir_pend_next_s   = redir_pend_r;
        redir_target_next_s = redir_target_r;
        suppress_req_s      = 1'b0;

        // Latch a taken branch; the in-flight/held word is its delay slot.
        if (branch_ok_s) begin
            redir_pend_next_s   = 1'b1;
            redir_target_next_s = branch_target_i;
        end else if (flush_i) begin
            redir_pend_next_s   = 1'b0;
        end else begin
            redir_pend_next_s   = redir_pend_r;
        end

        case (state_r)
            S_REQ: begin
                if (req_r && inst_bus.inst_addr_ok) begin
                    if (inst_bus.inst_data_ok) begin
                        if (flush_i) begin
                            // Word already back in the same cycle: just drop it.
                            pc_next_s    = sel_pc_s;
                            valid_next_s = 1'b0;
                            state_next_s = S_REQ;
                        end else begin
                            valid_next_s  = 1'b1;
                            instr_next_s  = inst_bus.inst_rdata;
                            out_pc_next_s = pc_r;
                            adel_next_s   = 1'b0;
                            state_next_s  = S_HOLD;
                        end
                    end else begin
                        state_next_s = S_DATA;
                        if (flush_i) begin
                            cancel_next_s = 1'b1;
                            pc_next_s     = sel_pc_s;
                            valid_next_s  = 1'b0;
                        end else begin
                            cancel_next_s = 1'b0;
                        end
                    end
                end else if (flush_i) begin
                    // Drop the request for a cycle so the address never moves under a live request.
                    pc_next_s      = sel_pc_s;
                    valid_next_s   = 1'b0;
                    suppress_req_s = req_r;
                end else if (addr_misaligned(pc_r[1:0])) begin
                    valid_next_s  = 1'b1;
                    adel_next_s   = 1'b1;
                    instr_next_s  = '0;
                    out_pc_next_s = pc_r;
                    state_next_s  = S_HOLD;
                end else begin
                    valid_next_s = 1'b0;
                end
            end
            S_DATA: begin
                if (inst_bus.inst_data_ok) begin
                    if (cancel_r || flush_i) begin
                        cancel_next_s = 1'b0;
                        valid_next_s  = 1'b0;
                        state_next_s  = S_REQ;
                        if (flush_i) begin
                            pc_next_s = sel_pc_s;
                        end else begin
                            pc_next_s = pc_r;
                        end
                    end else begin
                        valid_next_s  = 1'b1;
                        instr_next_s  = inst_bus.inst_rdata;
                        out_pc_next_s = pc_r;
                        adel_next_s   = 1'b0;
                        state_next_s  = S_HOLD;
                    end
                end else if (flush_i) begin
                    cancel_next_s = 1'b1;
                    pc_next_s     = sel_pc_s;
                    valid_next_s  = 1'b0;
                end else begin
                    state_next_s = S_DATA;
                end
            end
            S_HOLD: begin
                if (flush_i) begin
                    pc_next_s    = sel_pc_s;
                    valid_next_s = 1'b0;
                    adel_next_s  = 1'b0;
                    state_next_s = S_REQ;
                end else if (!id_stall_i) begin
                    // Consumed: a pending target is used now, a new branch waits for its slot.
                    pc_next_s         = sel_pc_s;
                    valid_next_s      = 1'b0;
                    adel_next_s       = 1'b0;
                    redir_pend_next_s = branch_ok_s;
                    state_next_s      = S_REQ;
                end else begin
                    state_next_s = S_HOLD;
                end
            end
            default: begin
                valid_next_s = 1'b0;
                state_next_s = S_REQ;
            end
        endcase

        req_next_s = (state_next_s == S_REQ) && !addr_misaligned(pc_next_s[1:0])
                     && !suppress_req_s;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r        <= S_REQ;
            pc_r           <= RESET_PC;
            req_r          <= 1'b0;
            valid_r        <= 1'b0;
            instr_r        <= '0;
            out_pc_r       <= '0;
            adel_r         <= 1'b0;
            cancel_r       <= 1'b0;
            redir_pend_r   <= 1'b0;
            redir_target_r <= '0;
        end else begin
            state_r        <= state_next_s;
            pc_r           <= pc_next_s;
            req_r          <= req_next_s;
            valid_r        <= valid_next_s;
            instr_r        <= instr_next_s;
            out_pc_r       <= out_pc_next_s;
            adel_r         <= adel_next_s;
            cancel_r       <= cancel_next_s;
            redir_pend_r   <= redir_pend_next_s;
            redir_target_r <= redir_target_next_s;
        end
    end

    assign inst_bus.inst_req  = req_r;
    assign inst_bus.inst_addr = pc_r;
    assign if_valid_o         = valid_r;
    assign if_instr_o         = instr_r;
    assign if_pc_o            = out_pc_r;
    assign if_adel_o          = adel_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: drives the instruction port and the
// decode/commit side from one linear sequence, checking outputs on the
// falling edge with hand-computed expectations.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        if_adel_o;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_if #(.DATA_W(32)) inst_bus ();

    instr_fetch #(.RESET_PC(32'hBFC0_0000), .DATA_W(32)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_bus        (inst_bus),
        .id_stall_i      (id_stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .if_valid_o      (if_valid_o),
        .if_instr_o      (if_instr_o),
        .if_pc_o         (if_pc_o),
        .if_adel_o       (if_adel_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One fetch with addr_ok and data_ok in the request cycle, then consumed.
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word,
                         input logic br, input logic [31:0] tgt);
        chk("fetch_req", {31'd0, inst_bus.inst_req}, 32'd1);
        chk("fetch_addr", inst_bus.inst_addr, exp_addr);
        inst_bus.inst_addr_ok = 1'b1;
        inst_bus.inst_data_ok = 1'b1;
        inst_bus.inst_rdata   = word;
        @(negedge clk);
        chk("fetch_valid", {31'd0, if_valid_o}, 32'd1);
        chk("fetch_pc", if_pc_o, exp_addr);
        chk("fetch_instr", if_instr_o, word);
        inst_bus.inst_addr_ok = 1'b0;
        inst_bus.inst_data_ok = 1'b0;
        branch_taken_i        = br;
        branch_target_i       = tgt;
        @(negedge clk);
        branch_taken_i = 1'b0;
        chk("fetch_consumed", {31'd0, if_valid_o}, 32'd0);
    endtask

    initial begin
        resetn                = 1'b0;
        id_stall_i            = 1'b0;
        branch_taken_i        = 1'b0;
        branch_target_i       = 32'd0;
        flush_i               = 1'b0;
        flush_pc_i            = 32'd0;
        inst_bus.inst_addr_ok = 1'b0;
        inst_bus.inst_data_ok = 1'b0;
        inst_bus.inst_rdata   = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, inst_bus.inst_req}, 32'd0);
        chk("rst_valid", {31'd0, if_valid_o}, 32'd0);
        chk("rst_instr", if_instr_o, 32'd0);
        chk("rst_pc", if_pc_o, 32'd0);
        chk("rst_adel", {31'd0, if_adel_o}, 32'd0);

        // First fetch: addr_ok immediately, data_ok two cycles later
        resetn = 1'b1;
        @(negedge clk);
        chk("boot_req", {31'd0, inst_bus.inst_req}, 32'd1);
        chk("boot_addr", inst_bus.inst_addr, 32'hBFC0_0000);
        inst_bus.inst_addr_ok = 1'b1;
        @(negedge clk);
        chk("one_outstanding", {31'd0, inst_bus.inst_req}, 32'd0);
        inst_bus.inst_addr_ok = 1'b0;
        @(negedge clk);
        chk("boot_wait_valid", {31'd0, if_valid_o}, 32'd0);
        inst_bus.inst_data_ok = 1'b1;
        inst_bus.inst_rdata   = 32'h3C08_0001;
        @(negedge clk);
        chk("boot_valid", {31'd0, if_valid_o}, 32'd1);
        chk("boot_instr", if_instr_o, 32'h3C08_0001);
        chk("boot_pc", if_pc_o, 32'hBFC0_0000);
        chk("boot_adel", {31'd0, if_adel_o}, 32'd0);
        inst_bus.inst_data_ok = 1'b0;
        @(negedge clk);
        chk("seq_req", {31'd0, inst_bus.inst_req}, 32'd1);
        chk("seq_addr", inst_bus.inst_addr, 32'hBFC0_0004);
        chk("seq_valid_drop", {31'd0, if_valid_o}, 32'd0);

        // Decode stall holds the delivered word
        inst_bus.inst_addr_ok = 1'b1;
        inst_bus.inst_data_ok = 1'b1;
        inst_bus.inst_rdata   = 32'h8C09_0004;
        id_stall_i            = 1'b1;
        @(negedge clk);
        chk("hold_valid", {31'd0, if_valid_o}, 32'd1);
        chk("hold_pc", if_pc_o, 32'hBFC0_0004);
        inst_bus.inst_addr_ok = 1'b0;
        inst_bus.inst_data_ok = 1'b0;
        inst_bus.inst_rdata   = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_instr", if_instr_o, 32'h8C09_0004);
            chk("hold_pc_stable", if_pc_o, 32'hBFC0_0004);
            chk("hold_no_req", {31'd0, inst_bus.inst_req}, 32'd0);
            chk("hold_valid_stable", {31'd0, if_valid_o}, 32'd1);
        end
        id_stall_i = 1'b0;
        @(negedge clk);
        chk("unstall_req", {31'd0, inst_bus.inst_req}, 32'd1);
        chk("unstall_addr", inst_bus.inst_addr, 32'hBFC0_0008);

        // Branch at BFC00010, delay slot BFC00014, then target
        fetch(32'hBFC0_0008, 32'h0000_0008, 1'b0, 32'd0);
        fetch(32'hBFC0_000C, 32'h0000_000C, 1'b0, 32'd0);
        fetch(32'hBFC0_0010, 32'h1000_003B, 1'b1, 32'h8000_0100);
        fetch(32'hBFC0_0014, 32'h0000_0000, 1'b0, 32'd0);
        chk("branch_target_req", {31'd0, inst_bus.inst_req}, 32'd1);
        chk("branch_target_addr", inst_bus.inst_addr, 32'h8000_0100);

        // Flush while waiting for data: returning word is discarded
        inst_bus.inst_addr_ok = 1'b1;
        @(negedge clk);
        chk("flush_sdata_noreq", {31'd0, inst_bus.inst_req}, 32'd0);
        inst_bus.inst_addr_ok = 1'b0;
        flush_i               = 1'b1;
        flush_pc_i            = 32'hBFC0_0380;
        @(negedge clk);
        flush_i               = 1'b0;
        chk("flush_sdata_valid0", {31'd0, if_valid_o}, 32'd0);
        inst_bus.inst_data_ok = 1'b1;
        inst_bus.inst_rdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        inst_bus.inst_data_ok = 1'b0;
        chk("flush_discard_valid", {31'd0, if_valid_o}, 32'd0);
        chk("flush_req", {31'd0, inst_bus.inst_req}, 32'd1);
        chk("flush_addr", inst_bus.inst_addr, 32'hBFC0_0380);

        // Flush and branch together: flush wins
        inst_bus.inst_addr_ok = 1'b1;
        inst_bus.inst_data_ok = 1'b1;
        inst_bus.inst_rdata   = 32'h0000_0380;
        @(negedge clk);
        chk("fb_valid", {31'd0, if_valid_o}, 32'd1);
        chk("fb_pc", if_pc_o, 32'hBFC0_0380);
        inst_bus.inst_addr_ok = 1'b0;
        inst_bus.inst_data_ok = 1'b0;
        flush_i               = 1'b1;
        flush_pc_i            = 32'hBFC0_0380;
        branch_taken_i        = 1'b1;
        branch_target_i       = 32'h8000_0200;
        @(negedge clk);
        flush_i        = 1'b0;
        branch_taken_i = 1'b0;
        chk("fb_valid_drop", {31'd0, if_valid_o}, 32'd0);
        fetch(32'hBFC0_0380, 32'h0000_0380, 1'b0, 32'd0);
        chk("fb_no_target_addr", inst_bus.inst_addr, 32'hBFC0_0384);

        // Jump to a misaligned target after its delay slot: AdEL delivered
        fetch(32'hBFC0_0384, 32'h0800_0040, 1'b1, 32'h8000_0102);
        fetch(32'hBFC0_0388, 32'h0000_0000, 1'b0, 32'd0);
        chk("adel_noreq_a", {31'd0, inst_bus.inst_req}, 32'd0);
        id_stall_i = 1'b1;
        @(negedge clk);
        chk("adel_noreq_b", {31'd0, inst_bus.inst_req}, 32'd0);
        chk("adel_valid", {31'd0, if_valid_o}, 32'd1);
        chk("adel_flag", {31'd0, if_adel_o}, 32'd1);
        chk("adel_instr", if_instr_o, 32'd0);
        chk("adel_pc", if_pc_o, 32'h8000_0102);

        // Asynchronous reset mid-run clears outputs at once
        resetn = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, if_valid_o}, 32'd0);
        chk("async_rst_adel", {31'd0, if_adel_o}, 32'd0);
        chk("async_rst_req", {31'd0, inst_bus.inst_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
